// File: rtl/opo_lock_pkg.sv
// Shared types and helpers for the OPO cavity lock detector.
package opo_lock_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    HOLD     = 2'd3
  } lock_state_t;

  // Increment that sticks at the all-ones value of a w-bit field (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/lock_detector_if.sv
// Sample stream and lock configuration from the IIR stage / register map into the lock detector.
interface lock_detector_if #(
  parameter int NUM_BITS = 16,
  parameter int CNT_BITS = 20
);
  logic signed [NUM_BITS-1:0] in_data;
  logic                       in_valid;
  logic signed [NUM_BITS-1:0] win_lo;
  logic signed [NUM_BITS-1:0] win_hi;
  logic        [NUM_BITS-1:0] lost_margin;
  logic        [CNT_BITS-1:0] acq_count;
  logic        [CNT_BITS-1:0] lost_count;

  modport master (output in_data, in_valid, win_lo, win_hi, lost_margin, acq_count, lost_count);
  modport slave  (input  in_data, in_valid, win_lo, win_hi, lost_margin, acq_count, lost_count);
endinterface

// File: rtl/lock_detector_window_cmp.sv
// Stage 1: registered narrow-window and hysteresis-widened window compare, 1-cycle latency.
module lock_window_cmp #(
  parameter int NUM_BITS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [NUM_BITS-1:0] in_data,
  input  logic signed [NUM_BITS-1:0] win_lo,
  input  logic signed [NUM_BITS-1:0] win_hi,
  input  logic        [NUM_BITS-1:0] lost_margin,
  output logic                       narrow_q,
  output logic                       wide_q,
  output logic                       vld_q
);
  // Two guard bits keep the widened bounds exact for any margin and any bound.
  localparam int WB = NUM_BITS + 2;

  logic signed [WB-1:0] d_x, lo_w, hi_w;
  logic narrow_d, wide_d, vld_d;

  always_comb begin
    d_x  = {{2{in_data[NUM_BITS-1]}}, in_data};
    lo_w = $signed({{2{win_lo[NUM_BITS-1]}}, win_lo}) - $signed({2'b00, lost_margin});
    hi_w = $signed({{2{win_hi[NUM_BITS-1]}}, win_hi}) + $signed({2'b00, lost_margin});
    narrow_d = narrow_q;
    wide_d   = wide_q;
    vld_d    = in_valid;
    if (in_valid) begin
      narrow_d = (in_data >= win_lo) && (in_data <= win_hi);
      wide_d   = (d_x >= lo_w) && (d_x <= hi_w);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      narrow_q <= 1'b0;
      wide_q   <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      narrow_q <= narrow_d;
      wide_q   <= wide_d;
      vld_q    <= vld_d;
    end
  end
endmodule

// File: rtl/lock_detector.sv
// OPO lock detector: window compare with hysteresis, dwell FSM, lock-event counter.
// Optional LOCK_DET_MINMAX_EN adds min_data/max_data extreme tracking while locked.
module lock_detector
  import opo_lock_pkg::*;
#(
  parameter int NUM_BITS = 16,
  parameter int CNT_BITS = 20,
  parameter int EVT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  lock_detector_if.slave      s_if,
  output logic                locked,
  output logic [1:0]          state,
  output logic                in_window,
  output logic [EVT_BITS-1:0] lock_events
`ifdef LOCK_DET_MINMAX_EN
  ,
  output logic signed [NUM_BITS-1:0] min_data,
  output logic signed [NUM_BITS-1:0] max_data
`endif
);
  logic narrow_q, wide_q, vld_s1;

  lock_window_cmp #(.NUM_BITS(NUM_BITS)) u_cmp (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (s_if.in_valid),
    .in_data    (s_if.in_data),
    .win_lo     (s_if.win_lo),
    .win_hi     (s_if.win_hi),
    .lost_margin(s_if.lost_margin),
    .narrow_q   (narrow_q),
    .wide_q     (wide_q),
    .vld_q      (vld_s1)
  );

  // Dwell thresholds travel with their sample so a config change hits the next sample only.
  logic [CNT_BITS-1:0] eff_acq_d, eff_acq_q, eff_lost_d, eff_lost_q;

  always_comb begin
    eff_acq_d  = eff_acq_q;
    eff_lost_d = eff_lost_q;
    if (s_if.in_valid) begin
      eff_acq_d  = (s_if.acq_count  == '0) ? CNT_BITS'(1) : s_if.acq_count;
      eff_lost_d = (s_if.lost_count == '0) ? CNT_BITS'(1) : s_if.lost_count;
    end
  end

  lock_state_t         state_d, state_q;
  logic [CNT_BITS-1:0] cnt_d, cnt_q, cnt_inc;
  logic [EVT_BITS-1:0] evt_d, evt_q, evt_inc;
  logic                locked_d, locked_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    evt_d   = evt_q;
    cnt_inc = CNT_BITS'(sat_inc(32'(cnt_q), CNT_BITS));
    evt_inc = EVT_BITS'(sat_inc(32'(evt_q), EVT_BITS));
    if (vld_s1) begin
      case (state_q)
        UNLOCKED: if (narrow_q) begin
          // A one-sample dwell collapses ACQUIRE; it still counts as an acquisition.
          if (eff_acq_q == CNT_BITS'(1)) begin
            state_d = LOCKED;
            evt_d   = evt_inc;
          end else begin
            state_d = ACQUIRE;
            cnt_d   = CNT_BITS'(1);
          end
        end
        ACQUIRE: if (!narrow_q) begin
          state_d = UNLOCKED;
          cnt_d   = '0;
        end else if (cnt_inc >= eff_acq_q) begin
          state_d = LOCKED;
          cnt_d   = '0;
          evt_d   = evt_inc;
        end else cnt_d = cnt_inc;
        LOCKED: if (wide_q) cnt_d = '0;
        else if (eff_lost_q == CNT_BITS'(1)) begin
          state_d = UNLOCKED;
          cnt_d   = '0;
        end else begin
          state_d = HOLD;
          cnt_d   = CNT_BITS'(1);
        end
        HOLD: if (wide_q) begin
          state_d = LOCKED;
          cnt_d   = '0;
        end else if (cnt_inc >= eff_lost_q) begin
          state_d = UNLOCKED;
          cnt_d   = '0;
        end else cnt_d = cnt_inc;
        default: state_d = UNLOCKED;
      endcase
    end
    locked_d = (state_d == LOCKED) || (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= UNLOCKED;
      cnt_q      <= '0;
      evt_q      <= '0;
      locked_q   <= 1'b0;
      eff_acq_q  <= '0;
      eff_lost_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      evt_q      <= evt_d;
      locked_q   <= locked_d;
      eff_acq_q  <= eff_acq_d;
      eff_lost_q <= eff_lost_d;
    end
  end

  assign locked      = locked_q;
  assign state       = state_q;
  assign in_window   = narrow_q;
  assign lock_events = evt_q;

`ifdef LOCK_DET_MINMAX_EN
  logic signed [NUM_BITS-1:0] data_s1_d, data_s1_q, min_d, min_q, max_d, max_q;

  always_comb begin
    data_s1_d = s_if.in_valid ? s_if.in_data : data_s1_q;
    min_d     = min_q;
    max_d     = max_q;
    if (vld_s1 && locked_d) begin
      if (!locked_q) begin
        min_d = data_s1_q;
        max_d = data_s1_q;
      end else begin
        if (data_s1_q < min_q) min_d = data_s1_q;
        if (data_s1_q > max_q) max_d = data_s1_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_s1_q <= '0;
      min_q     <= '0;
      max_q     <= '0;
    end else begin
      data_s1_q <= data_s1_d;
      min_q     <= min_d;
      max_q     <= max_d;
    end
  end

  assign min_data = min_q;
  assign max_data = max_q;
`endif
endmodule

// File: tb/tb_lock_detector.sv
// Randomised self-checking bench for lock_detector against a run-length reference model.
module tb_lock_detector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lock_detector_if #(.NUM_BITS(16), .CNT_BITS(20)) ifc ();
  logic        locked, in_window;
  logic [1:0]  state;
  logic [15:0] lock_events;
`ifdef LOCK_DET_MINMAX_EN
  logic signed [15:0] min_data, max_data;
`endif

  lock_detector #(.NUM_BITS(16), .CNT_BITS(20), .EVT_BITS(16)) dut (
    .clk(clk), .rst(rst), .s_if(ifc),
    .locked(locked), .state(state), .in_window(in_window), .lock_events(lock_events)
`ifdef LOCK_DET_MINMAX_EN
    , .min_data(min_data), .max_data(max_data)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: state code, length of the current hit/miss streak, event count.
  int m_state, m_run, m_events, m_min, m_max;
  bit m_win;
  bit p_v, p_n, p_w;
  int p_acq, p_lost, p_data;

  wire [19:0] got_vec = {state, locked, in_window, lock_events};

  function automatic logic [19:0] exp_vec();
    return {2'(m_state), (m_state >= 2), m_win, 16'(m_events)};
  endfunction

  task automatic apply();
    int prev;
    prev = m_state;
    if (m_state < 2) begin
      if (!p_n) begin m_state = 0; m_run = 0; end
      else begin
        m_run++;
        if (m_run >= p_acq) begin
          m_state = 2; m_run = 0;
          if (m_events < 65535) m_events++;
        end else m_state = 1;
      end
    end else begin
      if (p_w) begin m_state = 2; m_run = 0; end
      else begin
        m_run++;
        if (m_run >= p_lost) begin m_state = 0; m_run = 0; end
        else m_state = 3;
      end
    end
    if (m_state >= 2) begin
      if (prev < 2) begin m_min = p_data; m_max = p_data; end
      else begin
        if (p_data < m_min) m_min = p_data;
        if (p_data > m_max) m_max = p_data;
      end
    end
  endtask

  task automatic model_edge();
    int d, lo, hi, mg;
    if (rst) begin
      m_state = 0; m_run = 0; m_events = 0; m_win = 0; p_v = 0; m_min = 0; m_max = 0;
      return;
    end
    if (p_v) apply();
    p_v = ifc.in_valid;
    if (ifc.in_valid) begin
      d  = int'(ifc.in_data);
      lo = int'(ifc.win_lo);
      hi = int'(ifc.win_hi);
      mg = int'(ifc.lost_margin);
      p_n = (d >= lo) && (d <= hi);
      p_w = (d >= lo - mg) && (d <= hi + mg);
      m_win  = p_n;
      p_acq  = (ifc.acq_count == 0) ? 1 : int'(ifc.acq_count);
      p_lost = (ifc.lost_count == 0) ? 1 : int'(ifc.lost_count);
      p_data = d;
    end
  endtask

  task automatic cfg(input int lo, input int hi, input int mg, input int acq, input int lost);
    ifc.win_lo = 16'(lo); ifc.win_hi = 16'(hi); ifc.lost_margin = 16'(mg);
    ifc.acq_count = 20'(acq); ifc.lost_count = 20'(lost);
  endtask

  task automatic step(input bit v, input int d);
    @(negedge clk);
    rst = 1'b0; ifc.in_valid = v; ifc.in_data = 16'(d);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rst_step(input bit v, input int d);
    @(negedge clk);
    rst = 1'b1; ifc.in_valid = v; ifc.in_data = 16'(d);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    cfg(-100, 100, 0, 4, 1);
    rst_step(1, 0);
    rst_step(1, 0);
    checks++;
    if (got_vec !== 20'h0) begin
      errors++; $display("FAIL reset: got %h want %h", got_vec, 20'h0);
    end
  endtask

  task automatic test_acquire();
    for (int i = 1; i <= 6; i++) begin
      step(1, 0);
      checks++;
      if (got_vec !== exp_vec()) begin
        errors++; $display("FAIL acquire step %0d: got %h want %h", i, got_vec, exp_vec());
      end
      if (i == 4) begin
        checks++;
        if (state !== 2'd1 || locked !== 1'b0) begin
          errors++; $display("FAIL acquire_pre: got st=%0d lk=%0b want st=1 lk=0", state, locked);
        end
      end
      if (i == 5) begin
        checks++;
        if (state !== 2'd2 || locked !== 1'b1 || lock_events !== 16'd1) begin
          errors++; $display("FAIL acquire_lock: got st=%0d lk=%0b ev=%0d want 2 1 1", state, locked, lock_events);
        end
      end
    end
  endtask

  task automatic test_hysteresis();
    cfg(-100, 100, 50, 4, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, 140);
      checks++;
      if (got_vec !== exp_vec()) begin
        errors++; $display("FAIL hyst_stay %0d: got %h want %h", i, got_vec, exp_vec());
      end
    end
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL hyst_locked: got %0d want 2", state); end
    cfg(-100, 100, 50, 4, 3);
    for (int i = 0; i < 3; i++) step(1, 200);
    checks++;
    if (state !== 2'd3 || locked !== 1'b1) begin
      errors++; $display("FAIL hyst_hold: got st=%0d lk=%0b want 3 1", state, locked);
    end
    step(0, 0);
    checks++;
    if (state !== 2'd0 || locked !== 1'b0 || lock_events !== 16'd1) begin
      errors++; $display("FAIL hyst_unlock: got st=%0d lk=%0b ev=%0d want 0 0 1", state, locked, lock_events);
    end
  endtask

  task automatic test_abort();
    rst_step(0, 0);
    cfg(-100, 100, 0, 8, 1);
    for (int i = 0; i < 5; i++) step(1, int'($urandom_range(0, 200)) - 100);
    step(1, -101);
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL abort_acq: got %0d want 1", state); end
    step(0, 0);
    checks++;
    if (got_vec !== exp_vec() || state !== 2'd0 || lock_events !== 16'd0) begin
      errors++; $display("FAIL abort: got %h want %h", got_vec, exp_vec());
    end
  endtask

  task automatic test_empty_window();
    cfg(200, -200, 300, 1, 1);
    for (int i = 0; i < 1000; i++) begin
      step(1, int'($urandom_range(0, 65535)) - 32768);
      checks++;
      if (state !== 2'd0 || in_window !== 1'b0 || got_vec !== exp_vec()) begin
        errors++; $display("FAIL empty_window %0d: got %h want %h", i, got_vec, exp_vec());
      end
    end
  endtask

  task automatic test_boundary();
    rst_step(0, 0);
    cfg(-32768, 0, 'hFFFF, 1, 5);
    step(1, -32768);
    checks++;
    if (in_window !== 1'b1) begin errors++; $display("FAIL bnd_narrow: got %0b want 1", in_window); end
    step(1, 32767);
    step(1, -32768);
    step(0, 0);
    checks++;
    if (state !== 2'd2 || got_vec !== exp_vec()) begin
      errors++; $display("FAIL bnd_wide: got %h want %h", got_vec, exp_vec());
    end
    cfg(-32768, 0, 0, 1, 5);
    step(1, 100);
    step(0, 0);
    checks++;
    if (state !== 2'd3) begin errors++; $display("FAIL bnd_hold: got %0d want 3", state); end
    rst_step(1, -5);
    checks++;
    if (got_vec !== 20'h0) begin errors++; $display("FAIL bnd_rst: got %h want 0", got_vec); end
    step(0, 0);
    checks++;
    if (got_vec !== 20'h0 || got_vec !== exp_vec()) begin
      errors++; $display("FAIL bnd_rst_hold: got %h want 0", got_vec);
    end
  endtask

  task automatic test_random();
    rst_step(0, 0);
    for (int i = 0; i < 3000; i++) begin
      if (i % 60 == 0)
        cfg(int'($urandom_range(0, 200)) - 200, int'($urandom_range(0, 200)) - ($urandom_range(0, 9) == 0 ? 400 : 0),
            int'($urandom_range(0, 100)), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 800)) - 400);
      checks++;
      if (got_vec !== exp_vec()) begin
        errors++; $display("FAIL random %0d: got %h want %h", i, got_vec, exp_vec());
      end
    end
  endtask

`ifdef LOCK_DET_MINMAX_EN
  task automatic test_minmax();
    rst_step(0, 0);
    cfg(-100, 100, 0, 1, 1);
    step(1, 0); step(1, 10); step(1, -40); step(1, 70); step(1, 500); step(0, 0);
    checks++;
    if (min_data !== -16'sd40 || max_data !== 16'sd70 || int'(min_data) != m_min || int'(max_data) != m_max) begin
      errors++; $display("FAIL minmax: got %0d/%0d want -40/70", min_data, max_data);
    end
    step(1, 500); step(0, 0);
    checks++;
    if (min_data !== -16'sd40 || max_data !== 16'sd70 || locked !== 1'b0) begin
      errors++; $display("FAIL minmax_hold: got %0d/%0d want -40/70", min_data, max_data);
    end
  endtask
`endif

  initial begin
    ifc.in_valid = 1'b0;
    ifc.in_data  = '0;
    test_reset();
    test_acquire();
    test_hysteresis();
    test_abort();
    test_empty_window();
    test_boundary();
    test_random();
`ifdef LOCK_DET_MINMAX_EN
    test_minmax();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
